// File: rtl/branch_pkg.sv
// Shared constants for the chunked branch comparator: funct3 codes, FSM
// encoding and the taken/illegal decode.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMP  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Returns {taken, illegal}; 010/011 are the only illegal encodings.
    function automatic logic [1:0] decode_f3(input logic [2:0] f3, input logic eq,
                                             input logic lt, input logic ltu);
        logic [1:0] r;
        r = 2'b00;
        case (f3)
            F3_BEQ:  r = {eq, 1'b0};
            F3_BNE:  r = {!eq, 1'b0};
            F3_BLT:  r = {lt, 1'b0};
            F3_BGE:  r = {!lt, 1'b0};
            F3_BLTU: r = {ltu, 1'b0};
            F3_BGEU: r = {!ltu, 1'b0};
            default: r = 2'b01;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_cond_seq_if.sv
// Request/response handshake bundle between decode and the branch comparator.
interface branch_cond_seq_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [2:0]      funct3;
    logic            out_valid;
    logic            out_ready;
    logic            br_eq;
    logic            br_lt;
    logic            br_ltu;
    logic            taken;
    logic            illegal;

    modport master (output in_valid, rs1, rs2, funct3, out_ready,
                    input  in_ready, out_valid, br_eq, br_lt, br_ltu, taken, illegal);
    modport slave  (input  in_valid, rs1, rs2, funct3, out_ready,
                    output in_ready, out_valid, br_eq, br_lt, br_ltu, taken, illegal);
endinterface

// File: rtl/chunk_cmp.sv
// Combinational CHUNK-bit comparator; signed_en selects a two's-complement
// less-than for the most significant chunk.
module chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             signed_en,
    output logic             eq,
    output logic             lt
);
    assign eq = (a == b);
    assign lt = signed_en ? ($signed(a) < $signed(b)) : (a < b);
endmodule

// File: rtl/branch_cond_seq.sv
// Multi-cycle branch comparator: walks the operands MSB chunk first, stops at
// the first differing chunk and presents a registered taken/illegal result.
module branch_cond_seq
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_cond_seq_if.slave bus
);
    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (CHUNK < 1 || (XLEN % CHUNK) != 0) begin : g_bad_chunk
            $error("branch_cond_seq: XLEN must be a multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic [XLEN-1:0]  rs1_q, rs2_q;
    logic [2:0]       f3_q;
    logic             eq_q, lt_q, ltu_q, taken_q, illegal_q;

    logic [CHUNK-1:0] a_ch, b_ch;
    logic             first, last, c_eq, c_lt, c_ltu;

    assign first = (idx == '0);
    assign last  = (int'(idx) == NCHUNK - 1);

    always_comb begin
        a_ch = CHUNK'(rs1_q >> (XLEN - (int'(idx) + 1) * CHUNK));
        b_ch = CHUNK'(rs2_q >> (XLEN - (int'(idx) + 1) * CHUNK));
    end

    chunk_cmp #(.CHUNK(CHUNK)) u_cmp (
        .a         (a_ch),
        .b         (b_ch),
        .signed_en (first),
        .eq        (c_eq),
        .lt        (c_lt)
    );

    // On differing chunks the signed and unsigned orders disagree exactly when
    // the sign bits differ, so one comparator serves both.
    assign c_ltu = c_lt ^ (first & (a_ch[CHUNK-1] ^ b_ch[CHUNK-1]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            f3_q      <= '0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            ltu_q     <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    rs1_q <= bus.rs1;
                    rs2_q <= bus.rs2;
                    f3_q  <= bus.funct3;
                    idx   <= '0;
                    state <= CMP;
                end
                CMP: if (!c_eq) begin
                    eq_q                 <= 1'b0;
                    lt_q                 <= c_lt;
                    ltu_q                <= c_ltu;
                    {taken_q, illegal_q} <= decode_f3(f3_q, 1'b0, c_lt, c_ltu);
                    state                <= DONE;
                end else if (last) begin
                    eq_q                 <= 1'b1;
                    lt_q                 <= 1'b0;
                    ltu_q                <= 1'b0;
                    {taken_q, illegal_q} <= decode_f3(f3_q, 1'b1, 1'b0, 1'b0);
                    state                <= DONE;
                end else begin
                    idx <= idx + 1'b1;
                end
                DONE: if (bus.out_ready) begin
                    // Flags must read 0 whenever out_valid is low.
                    eq_q      <= 1'b0;
                    lt_q      <= 1'b0;
                    ltu_q     <= 1'b0;
                    taken_q   <= 1'b0;
                    illegal_q <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.br_eq     = eq_q;
    assign bus.br_lt     = lt_q;
    assign bus.br_ltu    = ltu_q;
    assign bus.taken     = taken_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_branch_cond_seq.sv
// Directed and random checks of branch_cond_seq at CHUNK = 8, 1 and 32, all
// three instances driven by the same request stream.
module tb_branch_cond_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [2:0]  funct3 = '0;

    always #5 clk = ~clk;

    branch_cond_seq_if #(.XLEN(32)) if8 ();
    branch_cond_seq_if #(.XLEN(32)) if1 ();
    branch_cond_seq_if #(.XLEN(32)) if32 ();

    assign if8.in_valid = in_valid;  assign if8.out_ready = out_ready;
    assign if8.rs1 = rs1;  assign if8.rs2 = rs2;  assign if8.funct3 = funct3;
    assign if1.in_valid = in_valid;  assign if1.out_ready = out_ready;
    assign if1.rs1 = rs1;  assign if1.rs2 = rs2;  assign if1.funct3 = funct3;
    assign if32.in_valid = in_valid; assign if32.out_ready = out_ready;
    assign if32.rs1 = rs1; assign if32.rs2 = rs2; assign if32.funct3 = funct3;

    branch_cond_seq #(.XLEN(32), .CHUNK(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    branch_cond_seq #(.XLEN(32), .CHUNK(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    branch_cond_seq #(.XLEN(32), .CHUNK(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    // {in_ready, out_valid, eq, lt, ltu, taken, illegal}; index 0=CHUNK8, 1=CHUNK1, 2=CHUNK32
    logic [2:0][6:0] obs;
    assign obs[0] = {if8.in_ready, if8.out_valid, if8.br_eq, if8.br_lt, if8.br_ltu, if8.taken, if8.illegal};
    assign obs[1] = {if1.in_ready, if1.out_valid, if1.br_eq, if1.br_lt, if1.br_ltu, if1.taken, if1.illegal};
    assign obs[2] = {if32.in_ready, if32.out_valid, if32.br_eq, if32.br_lt, if32.br_ltu, if32.taken, if32.illegal};

    int chunk_of [3] = '{8, 1, 32};
    int n_cmp = 0, n_bad = 0;
    int lat [3];
    logic [4:0] fl [3];

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  f3;
        int          lat8;
        logic [4:0]  fl;   // {eq, lt, ltu, taken, illegal}
    } vec_t;
    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                                  input int ch, output int k, output logic [4:0] f);
        logic e, l, u, t, il;
        logic [31:0] x, m;
        bit found;
        e  = (a == b);
        l  = $signed(a) < $signed(b);
        u  = a < b;
        il = (f3 == 3'b010) || (f3 == 3'b011);
        case (f3)
            3'b000: t = e;
            3'b001: t = !e;
            3'b100: t = l;
            3'b101: t = !l;
            3'b110: t = u;
            3'b111: t = !u;
            default: t = 1'b0;
        endcase
        m = (ch == 32) ? 32'hFFFF_FFFF : ((32'h1 << ch) - 32'h1);
        k = 32 / ch;
        found = 1'b0;
        for (int i = 0; i < 32 / ch; i++) begin
            x = ((a ^ b) >> (32 - (i + 1) * ch)) & m;
            if (!found && x != 0) begin
                k = i + 1;
                found = 1'b1;
            end
        end
        f = {e, l, u, t, il};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
        int w;
        w = 0;
        while (!(obs[0][6] && obs[1][6] && obs[2][6]) && w < 60) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 60) chk("idle_timeout", 32'd1, 32'd0);
        rs1 = a; rs2 = b; funct3 = f3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Records latency (edges after accept) and flags of each instance.
    task automatic collect();
        bit seen [3];
        for (int d = 0; d < 3; d++) begin seen[d] = 1'b0; lat[d] = -1; fl[d] = '0; end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++)
                if (!seen[d] && obs[d][5]) begin
                    seen[d] = 1'b1; lat[d] = c; fl[d] = obs[d][4:0];
                end
            if (seen[0] && seen[1] && seen[2]) break;
        end
    endtask

    initial begin
        int k;
        logic [4:0] ef;
        logic [31:0] a, b;
        int hits;

        vecs[0]  = '{32'h12345678, 32'h12345678, 3'b000, 4, 5'b10010};
        vecs[1]  = '{32'h80000000, 32'h00000001, 3'b100, 1, 5'b01010};
        vecs[2]  = '{32'h80000000, 32'h00000001, 3'b110, 1, 5'b01000};
        vecs[3]  = '{32'h000000FE, 32'h000000FF, 3'b111, 4, 5'b01100};
        vecs[4]  = '{32'h00010000, 32'h00020000, 3'b101, 2, 5'b01100};
        vecs[5]  = '{32'h12345678, 32'h12345679, 3'b001, 4, 5'b01110};
        vecs[6]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 3'b100, 1, 5'b00100};
        vecs[7]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 3'b101, 1, 5'b00110};
        vecs[8]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 3'b111, 1, 5'b00100};
        vecs[9]  = '{32'h00000500, 32'h00000400, 3'b010, 3, 5'b00001};
        vecs[10] = '{32'hAAAA0000, 32'hAAAA0000, 3'b011, 4, 5'b10001};
        vecs[11] = '{32'hFFFFFFFF, 32'h00000000, 3'b110, 1, 5'b01000};
        vecs[12] = '{32'h00000000, 32'h00000000, 3'b101, 4, 5'b10010};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {25'd0, obs[0]}, 32'h40);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", {25'd0, obs[0]}, 32'h40);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].f3);
            collect();
            chk($sformatf("vec%0d_lat8", i), lat[0], vecs[i].lat8);
            for (int d = 0; d < 3; d++)
                chk($sformatf("vec%0d_flags_c%0d", i, chunk_of[d]), {27'd0, fl[d]}, {27'd0, vecs[i].fl});
            @(posedge clk); #1;
            chk($sformatf("vec%0d_back_idle", i), {25'd0, obs[0]}, 32'h40);
        end

        // Stall the consumer: result must hold and new requests are ignored.
        out_ready = 1'b0;
        issue(32'h00000500, 32'h00000400, 3'b010);
        hits = 0;
        for (int c = 0; c < 20 && !obs[0][5]; c++) begin @(posedge clk); #1; end
        chk("hold_reached_done", {31'd0, obs[0][5]}, 32'd1);
        in_valid = 1'b1; rs1 = 32'h1; rs2 = 32'h2; funct3 = 3'b000;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("hold_cyc%0d", c), {25'd0, obs[0]}, 32'h21);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release", {25'd0, obs[0]}, 32'h40);

        // Reset in the middle of a compare discards the request.
        issue(32'h12345678, 32'h12345678, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {25'd0, obs[0]}, 32'h40);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (obs[0][5] || obs[1][5] || obs[2][5]) hits++;
        end
        chk("midrst_no_result", hits, 0);
        issue(32'h80000000, 32'h00000001, 3'b100);
        collect();
        chk("after_rst_lat8", lat[0], 1);
        chk("after_rst_flags", {27'd0, fl[0]}, 32'h0A);

        // Random operands across all funct3 and all three chunk widths.
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case (i % 3)
                0: b = a;
                1: b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            issue(a, b, 3'(i % 8));
            collect();
            for (int d = 0; d < 3; d++) begin
                model(a, b, 3'(i % 8), chunk_of[d], k, ef);
                chk($sformatf("rnd%0d_lat_c%0d", i, chunk_of[d]), lat[d], k);
                chk($sformatf("rnd%0d_flags_c%0d", i, chunk_of[d]), {27'd0, fl[d]}, {27'd0, ef});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
